// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//
// Converts RV32I load/store requests (LB/LH/LW/LBU/LHU/SB/SH/SW) into accesses
// on a word-addressed data memory. The memory can only read and write whole
// words:
//   - sub-word stores are done as a read-modify-write
//   - loads extract the addressed byte or half and sign- or zero-extend it
// Misaligned accesses and illegal funct3 encodings never reach memory. They
// complete one cycle after accept with resp_err=1.
//
// Ports
//   clk, rst                      clock; synchronous active-high reset
//   req_valid / req_ready         request handshake; one request in flight
//   req_we, req_funct3            1=store / 0=load; RV32I width encoding
//   req_addr, req_wdata           byte address; store data
//   resp_valid                    one-cycle completion pulse
//   resp_rdata                    extended load data (0 for stores and errors)
//   resp_err                      misaligned or illegal funct3
//   mem_readmem / mem_writemem    memory read / write enables
//   mem_addr                      word-aligned address of the latched request
//   mem_write_data                full word to write (0 outside WRITE)
//   mem_read_data                 combinational memory read data
// -----------------------------------------------------------------------------
module load_store_unit #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              mem_readmem,
    output logic              mem_writemem,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data
);

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RMW_RD,
        WRITE,
        RESP
    } state_t;

    state_t state_q, state_d;

    // Latched request. buf_q holds the store data from accept onwards. For
    // SB/SH it is then overwritten with the merged word, so it also serves as
    // the write buffer.
    logic [ADDR_W-1:0] addr_q;
    logic [2:0]        funct3_q;
    logic [DATA_W-1:0] buf_q;
    logic [DATA_W-1:0] resp_rdata_q;
    logic              resp_err_q;

    logic accept;
    logic req_illegal;
    logic req_misaligned;
    logic req_error;

    // ---------------------------------------------------------------- decode
    // NOTE: every signal assigned in an always_comb gets a default first;
    // a path that leaves one unassigned would infer a latch.
    always_comb begin
        req_illegal    = 1'b1;
        req_misaligned = 1'b0;
        case (req_funct3)
            F3_B: req_illegal = 1'b0;
            F3_H: begin
                req_illegal    = 1'b0;
                req_misaligned = req_addr[0];
            end
            F3_W: begin
                req_illegal    = 1'b0;
                req_misaligned = |req_addr[1:0];
            end
            // Unsigned widths exist only for loads.
            F3_BU: req_illegal = req_we;
            F3_HU: begin
                req_illegal    = req_we;
                req_misaligned = req_addr[0];
            end
            default: req_illegal = 1'b1;
        endcase
    end

    assign req_error = req_illegal | req_misaligned;
    assign accept    = req_valid & req_ready;

    // ----------------------------------------------- load extract / RMW merge
    logic [DATA_W-1:0] rd_shifted;
    logic [7:0]        rd_byte;
    logic [15:0]       rd_half;
    logic [DATA_W-1:0] load_data;
    logic [DATA_W-1:0] merged;

    assign rd_shifted = mem_read_data >> {addr_q[1:0], 3'b000};
    assign rd_byte    = rd_shifted[7:0];
    assign rd_half    = addr_q[1] ? mem_read_data[31:16] : mem_read_data[15:0];

    always_comb begin
        load_data = '0;
        case (funct3_q)
            F3_B:    load_data = {{24{rd_byte[7]}}, rd_byte};
            F3_H:    load_data = {{16{rd_half[15]}}, rd_half};
            F3_W:    load_data = mem_read_data;
            F3_BU:   load_data = {24'h0, rd_byte};
            F3_HU:   load_data = {16'h0, rd_half};
            default: load_data = '0;
        endcase
    end

    always_comb begin
        merged = mem_read_data;
        if (funct3_q == F3_B) begin
            merged[{addr_q[1:0], 3'b000} +: 8] = buf_q[7:0];
        end else begin
            merged[{addr_q[1], 4'b0000} +: 16] = buf_q[15:0];
        end
    end

    // ------------------------------------------------------------ FSM state
    // NOTE: sequential state uses non-blocking assignments so that every
    // register samples values from before the clock edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------- FSM next state and outputs
    // Memory enables, req_ready and resp_valid are all forced low while rst is
    // high. An in-flight RMW therefore never writes and an aborted request
    // never signals completion.
    always_comb begin
        state_d        = state_q;
        req_ready      = 1'b0;
        mem_readmem    = 1'b0;
        mem_writemem   = 1'b0;
        mem_write_data = '0;
        resp_valid     = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = !rst;
                if (accept) begin
                    if (req_error)              state_d = RESP;
                    else if (!req_we)           state_d = LOAD;
                    else if (req_funct3 == F3_W) state_d = WRITE;
                    else                        state_d = RMW_RD;
                end
            end
            LOAD: begin
                mem_readmem = !rst;
                state_d     = RESP;
            end
            RMW_RD: begin
                mem_readmem = !rst;
                state_d     = WRITE;
            end
            WRITE: begin
                mem_writemem   = !rst;
                mem_write_data = buf_q;
                state_d        = RESP;
            end
            RESP: begin
                resp_valid = !rst;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // -------------------------------------------------------------- datapath
    // NOTE: the latched request, the merge buffer and the response registers
    // are all reset, so nothing from before reset can leak into a response.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q       <= '0;
            funct3_q     <= '0;
            buf_q        <= '0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        addr_q       <= req_addr;
                        funct3_q     <= req_funct3;
                        buf_q        <= req_wdata;
                        resp_rdata_q <= '0;
                        resp_err_q   <= req_error;
                    end
                end
                LOAD:    resp_rdata_q <= load_data;
                RMW_RD:  buf_q        <= merged;
                default: ;
            endcase
        end
    end

    assign mem_addr   = {addr_q[ADDR_W-1:2], 2'b00};
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// Testbench for load_store_unit.
// - A small word memory model answers reads combinationally and commits
//   writes on the clock edge.
// - Inputs are driven just after posedge. Outputs are sampled on negedge.
// -----------------------------------------------------------------------------
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_readmem;
    logic        mem_writemem;
    logic [31:0] mem_addr;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [0:63];

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_we         (req_we),
        .req_funct3     (req_funct3),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .resp_err       (resp_err),
        .mem_readmem    (mem_readmem),
        .mem_writemem   (mem_writemem),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data)
    );

    assign mem_read_data = mem[mem_addr[7:2]];

    always @(posedge clk) begin
        if (mem_writemem) mem[mem_addr[7:2]] <= mem_write_data;
    end

    // Issue one request and wait for its response. The task reports:
    //   lat          cycles from the accept edge to resp_valid
    //   rdata, err   the response captured in the resp_valid cycle
    //   rd_cyc/wr_cyc  memory read/write cycles seen while waiting
    // An expired wait counts as a failed comparison.
    task automatic issue(input logic we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d,
                         output int lat, output logic [31:0] rdata,
                         output logic err, output int rd_cyc, output int wr_cyc);
        int n;
        lat = 0; rdata = 'x; err = 1'bx; rd_cyc = 0; wr_cyc = 0;
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = d;
        @(negedge clk);
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            checks++; errors++;
            $display("FAIL accept_timeout: req_ready never rose for addr %h", a);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (mem_readmem)  rd_cyc++;
            if (mem_writemem) wr_cyc++;
            if (resp_valid) begin
                lat = c; rdata = resp_rdata; err = resp_err;
                return;
            end
        end
        checks++; errors++;
        $display("FAIL resp_timeout: no resp_valid for addr %h", a);
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010;
        req_addr = 32'h10; req_wdata = 32'h0;
        repeat (3) @(negedge clk);
        checks++;
        if ({req_ready, resp_valid, mem_readmem, mem_writemem, resp_err} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 00000",
                     {req_ready, resp_valid, mem_readmem, mem_writemem, resp_err});
        end
        checks++;
        if (resp_rdata !== 32'h0 || mem_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: rdata %h addr %h expected 0", resp_rdata, mem_addr);
        end
        req_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset: got %b expected 1", req_ready);
        end
    endtask

    task automatic test_word();
        int lat, rd, wr; logic [31:0] q; logic e;
        issue(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, lat, q, e, rd, wr);
        checks++;
        if (lat !== 2 || e !== 1'b0 || q !== 32'h0 || rd !== 0 || wr !== 1) begin
            errors++;
            $display("FAIL sw: lat %0d err %b rdata %h rd %0d wr %0d expected 2 0 0 0 1",
                     lat, e, q, rd, wr);
        end
        checks++;
        if (mem[4] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL sw_mem: got %h expected deadbeef", mem[4]);
        end
        issue(1'b0, 3'b010, 32'h10, 32'h0, lat, q, e, rd, wr);
        checks++;
        if (lat !== 2 || e !== 1'b0 || q !== 32'hDEADBEEF || rd !== 1 || wr !== 0) begin
            errors++;
            $display("FAIL lw: lat %0d err %b rdata %h rd %0d wr %0d expected 2 0 deadbeef 1 0",
                     lat, e, q, rd, wr);
        end
    endtask

    task automatic test_byte();
        int lat, rd, wr; logic [31:0] q; logic e;
        issue(1'b1, 3'b000, 32'h11, 32'h000000A5, lat, q, e, rd, wr);
        checks++;
        if (lat !== 3 || e !== 1'b0 || rd !== 1 || wr !== 1) begin
            errors++;
            $display("FAIL sb: lat %0d err %b rd %0d wr %0d expected 3 0 1 1", lat, e, rd, wr);
        end
        checks++;
        if (mem[4] !== 32'hDEADA5EF) begin
            errors++;
            $display("FAIL sb_mem: got %h expected deada5ef", mem[4]);
        end
        issue(1'b0, 3'b000, 32'h11, 32'h0, lat, q, e, rd, wr);
        checks++;
        if (q !== 32'hFFFFFFA5 || e !== 1'b0) begin
            errors++;
            $display("FAIL lb: got %h err %b expected ffffffa5", q, e);
        end
        issue(1'b0, 3'b100, 32'h11, 32'h0, lat, q, e, rd, wr);
        checks++;
        if (q !== 32'h000000A5 || e !== 1'b0) begin
            errors++;
            $display("FAIL lbu: got %h err %b expected 000000a5", q, e);
        end
    endtask

    task automatic test_half();
        int lat, rd, wr; logic [31:0] q; logic e;
        issue(1'b1, 3'b001, 32'h12, 32'h00001234, lat, q, e, rd, wr);
        checks++;
        if (lat !== 3 || mem[4] !== 32'h1234A5EF) begin
            errors++;
            $display("FAIL sh: lat %0d mem %h expected 3 1234a5ef", lat, mem[4]);
        end
        issue(1'b0, 3'b001, 32'h12, 32'h0, lat, q, e, rd, wr);
        checks++;
        if (q !== 32'h00001234) begin
            errors++;
            $display("FAIL lh_hi: got %h expected 00001234", q);
        end
        issue(1'b0, 3'b001, 32'h10, 32'h0, lat, q, e, rd, wr);
        checks++;
        if (q !== 32'hFFFFA5EF) begin
            errors++;
            $display("FAIL lh_lo: got %h expected ffffa5ef", q);
        end
        issue(1'b0, 3'b101, 32'h10, 32'h0, lat, q, e, rd, wr);
        checks++;
        if (q !== 32'h0000A5EF) begin
            errors++;
            $display("FAIL lhu: got %h expected 0000a5ef", q);
        end
    endtask

    task automatic test_errors();
        int lat, rd, wr; logic [31:0] q; logic e;
        logic        we_v [3] = '{1'b0, 1'b1, 1'b0};
        logic [2:0]  f3_v [3] = '{3'b010, 3'b001, 3'b011};
        logic [31:0] a_v  [3] = '{32'h13, 32'h11, 32'h10};
        for (int i = 0; i < 3; i++) begin
            issue(we_v[i], f3_v[i], a_v[i], 32'hFFFFFFFF, lat, q, e, rd, wr);
            checks++;
            if (lat !== 1 || e !== 1'b1 || q !== 32'h0 || rd !== 0 || wr !== 0) begin
                errors++;
                $display("FAIL err_case%0d: lat %0d err %b rdata %h rd %0d wr %0d expected 1 1 0 0 0",
                         i, lat, e, q, rd, wr);
            end
        end
        checks++;
        if (mem[4] !== 32'h1234A5EF) begin
            errors++;
            $display("FAIL err_mem: got %h expected 1234a5ef", mem[4]);
        end
    endtask

    task automatic test_reset_mid_rmw();
        int lat, rd, wr; logic [31:0] q; logic e;
        int seen_write, seen_resp;
        seen_write = 0; seen_resp = 0;
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000;
        req_addr = 32'h10; req_wdata = 32'h77;
        @(negedge clk);
        @(posedge clk);                 // accept edge
        #1 req_valid = 1'b0;
        @(negedge clk);                 // RMW_RD
        @(posedge clk);                 // enter WRITE
        #1 rst = 1'b1;
        @(negedge clk);
        if (mem_writemem) seen_write++;
        if (resp_valid)   seen_resp++;
        @(posedge clk);
        #1 rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (mem_writemem) seen_write++;
            if (resp_valid)   seen_resp++;
            if (c == 0) begin
                checks++;
                if (req_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL rst_idle: req_ready %b expected 1", req_ready);
                end
            end
        end
        checks++;
        if (seen_write !== 0 || seen_resp !== 0) begin
            errors++;
            $display("FAIL rst_abort: writes %0d resps %0d expected 0 0", seen_write, seen_resp);
        end
        issue(1'b0, 3'b010, 32'h10, 32'h0, lat, q, e, rd, wr);
        checks++;
        if (q !== 32'h1234A5EF || e !== 1'b0) begin
            errors++;
            $display("FAIL rst_lw: got %h err %b expected 1234a5ef", q, e);
        end
    endtask

    task automatic test_back_to_back();
        logic        rdy [1:6];
        logic        vld [1:6];
        logic [31:0] dat [1:6];
        logic        exp_rdy [1:6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic        exp_vld [1:6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010;
        req_addr = 32'h10; req_wdata = 32'h0;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready0: got %b expected 1", req_ready);
        end
        @(posedge clk);                 // accept A (LW 0x10)
        #1 req_funct3 = 3'b100;         // queue B: LBU 0x10
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            rdy[c] = req_ready; vld[c] = resp_valid; dat[c] = resp_rdata;
            if (c == 4) req_valid = 1'b0;   // B was accepted at the end of cycle 3
        end
        for (int c = 1; c <= 6; c++) begin
            checks++;
            if (rdy[c] !== exp_rdy[c] || vld[c] !== exp_vld[c]) begin
                errors++;
                $display("FAIL b2b_cycle%0d: ready %b valid %b expected %b %b",
                         c, rdy[c], vld[c], exp_rdy[c], exp_vld[c]);
            end
        end
        checks++;
        if (dat[2] !== 32'h1234A5EF || dat[5] !== 32'h000000EF) begin
            errors++;
            $display("FAIL b2b_order: got %h %h expected 1234a5ef 000000ef", dat[2], dat[5]);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_errors();
        test_reset_mid_rmw();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
